uart_program_loader: RTL

- Boot-time programming sequencer between the SoC UART receiver and the core's instruction flash write port.
- Detects a start frame in the received byte stream and packs the following bytes into 32-bit words. Each word is written to flash at consecutive word addresses.
- Holds the core in reset while a load is in progress.
- On the end frame, releases the core and pulses program_done.

---
 rtl/uart_program_loader_if.sv | 23 ++
 rtl/uart_program_loader.sv | 97 +++++++++
 2 files changed

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: UART byte stream in, flash write port and core/status outputs of the program loader
interface uart_program_loader_if #(parameter int ADDR_WIDTH = 10);
  logic [7:0] rx_data;
  logic rx_valid;
  logic flash_write_enable;
  logic [ADDR_WIDTH-1:0] flash_write_address;
  logic [31:0] flash_write_data;
  logic core_hold;
  logic busy;
  logic program_done;
  logic load_error;
  logic [ADDR_WIDTH:0] word_count;
  modport master (
    output rx_data, rx_valid,
    input flash_write_enable, flash_write_address, flash_write_data,
    input core_hold, busy, program_done, load_error, word_count
  );
  modport slave (
    input rx_data, rx_valid,
    output flash_write_enable, flash_write_address, flash_write_data,
    output core_hold, busy, program_done, load_error, word_count
  );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: detects start frame on bus rx_data/rx_valid, packs LE words to bus flash_write_*, drives core_hold/busy/program_done/load_error/word_count
module uart_program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 1024,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input logic clk,
  input logic reset,
  uart_program_loader_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] FRAME = 32'h5aa50ff0;
  typedef enum logic {IDLE, LOAD} state_t;
  state_t r_state;
  logic [31:0] r_hist, r_word, r_data;
  logic [1:0] r_idx;
  logic [TW-1:0] r_to;
  logic r_we, r_hold, r_busy, r_done, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0] r_cnt;
  logic [31:0] w_hist, w_word;
  logic w_start;
  // start frame arrives MSB-first in the history; end frame packed LE gives the same constant
  assign w_hist = {r_hist[23:0], bus.rx_data};
  assign w_word = {bus.rx_data, r_word[31:8]};
  assign w_start = bus.rx_valid && w_hist == FRAME;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hist <= '0;
      r_word <= '0;
      r_data <= '0;
      r_idx <= '0;
      r_to <= '0;
      r_we <= 1'b0;
      r_hold <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_cnt <= '0;
    end else begin
      r_we <= 1'b0;
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.rx_valid) r_hist <= w_start ? '0 : w_hist;
        if (w_start) begin
          r_state <= LOAD;
          r_hold <= 1'b1;
          r_busy <= 1'b1;
          r_err <= 1'b0;
          r_cnt <= '0;
          r_idx <= '0;
          r_to <= '0;
          r_addr <= '0;
        end
      end else if (bus.rx_valid) begin
        r_to <= '0;
        r_idx <= r_idx + 2'd1;
        r_word <= w_word;
        if (r_idx == 2'd3) begin
          if (w_word == FRAME) begin
            r_state <= IDLE;
            r_hold <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else if (r_cnt < (ADDR_WIDTH + 1)'(DEPTH)) begin
            r_we <= 1'b1;
            r_addr <= r_cnt[ADDR_WIDTH-1:0];
            r_data <= w_word;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy <= 1'b0;
            r_err <= 1'b1;
          end
        end
      end else if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state <= IDLE;
        r_busy <= 1'b0;
        r_err <= 1'b1;
        r_idx <= '0;
        r_to <= '0;
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end
  assign bus.flash_write_enable = r_we;
  assign bus.flash_write_address = r_addr;
  assign bus.flash_write_data = r_data;
  assign bus.core_hold = r_hold;
  assign bus.busy = r_busy;
  assign bus.program_done = r_done;
  assign bus.load_error = r_err;
  assign bus.word_count = r_cnt;
endmodule
